// File: rtl/gearbox_48to64.sv
// Repacks an MSB-first stream of 48-bit words into 64-bit words.
// The output goes through a show-ahead FIFO with a valid/ready handshake. Overruns set a sticky overflow flag.
module gearbox_48to64 #(
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        din_flag,
    input  logic [47:0] din,
    input  logic        din_last,
    output logic [63:0] dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_last,
    output logic        overflow
);

    localparam int unsigned AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic {
        ST_IDLE,
        ST_FLUSH
    } state_t;

    state_t      state_q, state_d;
    logic [47:0] acc_q, acc_d;
    logic [1:0]  r_q, r_d;        // residual length in 16-bit units (0..3)
    logic        overflow_q, overflow_d;

    logic [95:0] stream;
    logic        push;
    logic        push_last;
    logic [63:0] push_word;
    logic        proto_err;

    logic [63:0]           mem_q [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mlast_q;
    logic [AW:0]           wptr_q, rptr_q;
    logic [AW:0]           count;
    logic                  empty;
    logic                  full;
    logic                  pop;
    logic                  wr_en;
    logic                  drop;

    // Residual bits are left-aligned and older than din, so din goes directly below them.
    always_comb begin
        unique case (r_q)
            2'd0: stream = {din, 48'h0};
            2'd1: stream = {acc_q[47:32], din, 32'h0};
            2'd2: stream = {acc_q[47:16], din, 16'h0};
            2'd3: stream = {acc_q, din};
        endcase
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        r_d       = r_q;
        push      = 1'b0;
        push_last = 1'b0;
        push_word = '0;
        proto_err = 1'b0;
        unique case (state_q)
            ST_FLUSH: begin
                push      = 1'b1;
                push_last = 1'b1;
                push_word = {acc_q, 16'h0};
                acc_d     = '0;
                r_d       = 2'd0;
                state_d   = ST_IDLE;
                proto_err = din_flag;
            end
            default: begin
                if (din_flag) begin
                    if (r_q == 2'd0) begin
                        if (din_last) begin
                            push      = 1'b1;
                            push_last = 1'b1;
                            push_word = {din, 16'h0};
                        end else begin
                            acc_d = din;
                            r_d   = 2'd3;
                        end
                    end else begin
                        push      = 1'b1;
                        push_word = stream[95:32];
                        acc_d     = {stream[31:0], 16'h0};
                        r_d       = r_q - 2'd1;
                        if (din_last) begin
                            if (r_q == 2'd1) begin
                                push_last = 1'b1;
                                acc_d     = '0;
                            end else begin
                                state_d = ST_FLUSH;
                            end
                        end
                    end
                end
            end
        endcase
    end

    assign count = wptr_q - rptr_q;
    assign empty = (count == '0);
    assign full  = count[AW];
    assign pop   = !empty && dout_ready;
    assign wr_en = push && (!full || pop);
    assign drop  = push && full && !pop;

    assign overflow_d = overflow_q || drop || proto_err;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            acc_q      <= '0;
            r_q        <= 2'd0;
            overflow_q <= 1'b0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            mlast_q    <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            r_q        <= r_d;
            overflow_q <= overflow_d;
            if (wr_en) begin
                mem_q[wptr_q[AW-1:0]]   <= push_word;
                mlast_q[wptr_q[AW-1:0]] <= push_last;
                wptr_q                  <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
        end
    end

    assign dout_valid = !empty;
    assign dout       = empty ? '0 : mem_q[rptr_q[AW-1:0]];
    assign dout_last  = !empty && mlast_q[rptr_q[AW-1:0]];
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_gearbox_48to64.sv
// Bench for gearbox_48to64: directed scenarios and a randomized phase, checked against a bit-queue reference model.
module tb_gearbox_48to64;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din_flag = 1'b0;
    logic [47:0] din = '0;
    logic        din_last = 1'b0;
    logic [63:0] dout;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic        dout_last;
    logic        overflow;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state: pending stream bits (earliest first), output queue, flags.
    logic        q_bits[$];
    logic [63:0] mf_data[$];
    logic        mf_last[$];
    logic        m_ovf;
    bit          m_flush;

    logic [47:0] wa, wb, wc, wd;

    gearbox_48to64 #(.FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din_flag  (din_flag),
        .din       (din),
        .din_last  (din_last),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_ready(dout_ready),
        .dout_last (dout_last),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q_bits.delete();
        mf_data.delete();
        mf_last.delete();
        m_ovf   = 1'b0;
        m_flush = 1'b0;
    endtask

    task automatic take_word(output logic [63:0] w);
        for (int i = 63; i >= 0; i--) begin
            if (q_bits.size() != 0) w[i] = q_bits.pop_front();
            else                    w[i] = 1'b0;
        end
    endtask

    task automatic model_step(input logic flag, input logic [47:0] d, input logic last, input logic ready);
        logic [63:0] w;
        logic        wl;
        bit          push;
        bit          pop;
        w    = '0;
        wl   = 1'b0;
        push = 1'b0;
        pop  = (mf_data.size() != 0) && ready;
        if (m_flush) begin
            take_word(w);
            wl      = 1'b1;
            push    = 1'b1;
            m_flush = 1'b0;
            if (flag) m_ovf = 1'b1;
        end else if (flag) begin
            for (int i = 47; i >= 0; i--) q_bits.push_back(d[i]);
            if (q_bits.size() >= 64) begin
                take_word(w);
                push = 1'b1;
                if (last) begin
                    if (q_bits.size() == 0) wl = 1'b1;
                    else                    m_flush = 1'b1;
                end
            end else if (last) begin
                take_word(w);
                wl   = 1'b1;
                push = 1'b1;
            end
        end
        if (pop) begin
            void'(mf_data.pop_front());
            void'(mf_last.pop_front());
        end
        if (push) begin
            if (mf_data.size() < DEPTH) begin
                mf_data.push_back(w);
                mf_last.push_back(wl);
            end else begin
                m_ovf = 1'b1;
            end
        end
    endtask

    task automatic compare_outputs(input string tag);
        check_eq({tag, ".valid"}, dout_valid, mf_data.size() != 0);
        if (mf_data.size() != 0) begin
            check_eq({tag, ".dout"}, dout, mf_data[0]);
            check_eq({tag, ".last"}, dout_last, mf_last[0]);
        end
        check_eq({tag, ".ovf"}, overflow, m_ovf);
    endtask

    task automatic step(input logic flag, input logic [47:0] d, input logic last,
                        input logic ready, input string tag);
        din_flag   = flag;
        din        = d;
        din_last   = last;
        dout_ready = ready;
        model_step(flag, d, last, ready);
        @(posedge clk);
        #1;
        compare_outputs(tag);
    endtask

    task automatic do_reset(input string tag);
        rst_n      = 1'b0;
        din_flag   = 1'b0;
        din_last   = 1'b0;
        dout_ready = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        check_eq({tag, ".valid"}, dout_valid, 1'b0);
        check_eq({tag, ".dout"}, dout, 64'h0);
        check_eq({tag, ".last"}, dout_last, 1'b0);
        check_eq({tag, ".ovf"}, overflow, 1'b0);
    endtask

    function automatic logic [47:0] rnd48();
        return {$urandom_range(0, 65535), $urandom()};
    endfunction

    task automatic four_words(input logic last_d, input string tag);
        step(1'b1, wa, 1'b0, 1'b1, tag);
        step(1'b1, wb, 1'b0, 1'b1, tag);
        check_eq({tag, ".w0"}, dout, {wa, wb[47:32]});
        step(1'b1, wc, 1'b0, 1'b1, tag);
        check_eq({tag, ".w1"}, dout, {wb[31:0], wc[47:16]});
        step(1'b1, wd, last_d, 1'b1, tag);
        check_eq({tag, ".w2"}, dout, {wc[15:0], wd});
        check_eq({tag, ".w2last"}, dout_last, last_d);
        step(1'b0, '0, 1'b0, 1'b1, tag);
        step(1'b0, '0, 1'b0, 1'b1, tag);
    endtask

    initial begin
        model_reset();
        do_reset("reset0");

        wa = rnd48();
        wb = rnd48();
        wc = rnd48();
        wd = rnd48();
        four_words(1'b0, "repack");

        step(1'b1, 48'h123456789ABC, 1'b1, 1'b1, "single");
        check_eq("single.word", dout, 64'h123456789ABC0000);
        check_eq("single.lastbit", dout_last, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1, "single.after");

        four_words(1'b1, "exact");

        for (int i = 0; i < 8; i++) begin
            step(1'b1, rnd48(), 1'b0, 1'b0, "bp.fill");
            if (i == 6) check_eq("bp.ovf7", overflow, 1'b1);
        end
        for (int i = 0; i < 6; i++) step(1'b0, '0, 1'b0, 1'b1, "bp.drain");
        step(1'b1, rnd48(), 1'b1, 1'b1, "bp.resume");
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b0, 1'b1, "bp.tail");

        do_reset("reset1");
        step(1'b1, wa, 1'b0, 1'b1, "flush");
        step(1'b1, wb, 1'b1, 1'b1, "flush");
        check_eq("flush.w0", dout, {wa, wb[47:32]});
        check_eq("flush.w0last", dout_last, 1'b0);
        step(1'b1, rnd48(), 1'b0, 1'b1, "flush.viol");
        check_eq("flush.pad", dout, {wb[31:0], 32'h0});
        check_eq("flush.padlast", dout_last, 1'b1);
        check_eq("flush.ovf", overflow, 1'b1);
        step(1'b0, '0, 1'b0, 1'b1, "flush.noextra");
        check_eq("flush.novalid", dout_valid, 1'b0);

        step(1'b1, rnd48(), 1'b0, 1'b0, "midrst");
        step(1'b1, rnd48(), 1'b0, 1'b0, "midrst");
        step(1'b1, rnd48(), 1'b0, 1'b0, "midrst");
        do_reset("midrst.reset");
        four_words(1'b0, "after_rst");

        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rand.reset");
            end else begin
                step($urandom_range(0, 3) != 0, rnd48(), $urandom_range(0, 7) == 0,
                     $urandom_range(0, 3) != 0, "rand");
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
